// File: rtl/feature_map_arbiter.sv
// Session arbiter for the shared feature-map BRAM (port A read, port B write).
// Grants whole sessions to conv (0) or fire (1) and maps {x,y} coordinates to linear addresses.
module feature_map_arbiter #(
  parameter int unsigned BITS_PER_COORDINATE = 8,
  parameter int unsigned IMG_WIDTH           = 32,
  parameter int unsigned IMG_HEIGHT          = 32,
  parameter int unsigned OUT_CHANNELS        = 4,
  parameter int unsigned BITS_PER_NEURON     = 12,
  localparam int unsigned DATA_W = OUT_CHANNELS * BITS_PER_NEURON,
  localparam int unsigned ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT),
  localparam int unsigned CW     = 2 * BITS_PER_COORDINATE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             s_session,
  output logic [1:0]             s_grant,
  input  logic [1:0]             s_rd_req,
  input  logic [1:0][CW-1:0]     s_rd_coord,
  output logic [1:0]             s_rd_valid,
  output logic [DATA_W-1:0]      s_rd_data,
  input  logic [1:0]             s_wr_req,
  input  logic [1:0][CW-1:0]     s_wr_coord,
  input  logic [1:0][DATA_W-1:0] s_wr_data,
  output logic                   bram_rd_en,
  output logic [ADDR_W-1:0]      bram_rd_addr,
  input  logic [DATA_W-1:0]      bram_rd_data,
  output logic                   bram_wr_en,
  output logic [ADDR_W-1:0]      bram_wr_addr,
  output logic [DATA_W-1:0]      bram_wr_data,
  output logic                   protocol_error
);
  localparam int unsigned BPC = BITS_PER_COORDINATE;

  typedef enum logic [1:0] {StIdle, StGrantConv, StGrantFire, StDrain} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rd_valid_q, rd_valid_d;
  logic        last_fire_q, last_fire_d;
  logic        err_q, err_d;
  logic        own;
  logic        rd_ok, wr_ok;

  function automatic logic coord_ok(input logic [CW-1:0] c);
    return (32'(c[CW-1 -: BPC]) < IMG_WIDTH) && (32'(c[BPC-1:0]) < IMG_HEIGHT);
  endfunction

  function automatic logic [ADDR_W-1:0] coord_addr(input logic [CW-1:0] c);
    return ADDR_W'(c[BPC-1:0]) * ADDR_W'(IMG_WIDTH) + ADDR_W'(c[CW-1 -: BPC]);
  endfunction

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_fire_d = last_fire_q;
    case (state_q)
      StIdle: begin
        // Round-robin on a tie: the requester that did not own the last session wins.
        if (s_session[0] && (!s_session[1] || last_fire_q)) begin
          state_d = StGrantConv;
          grant_d = 2'b01;
        end else if (s_session[1]) begin
          state_d = StGrantFire;
          grant_d = 2'b10;
        end
      end
      StGrantConv: begin
        if (!s_session[0]) begin
          state_d     = StDrain;
          grant_d     = 2'b00;
          last_fire_d = 1'b0;
        end
      end
      StGrantFire: begin
        if (!s_session[1]) begin
          state_d     = StDrain;
          grant_d     = 2'b00;
          last_fire_d = 1'b1;
        end
      end
      StDrain: state_d = StIdle;
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    own   = grant_q[1];
    rd_ok = (grant_q != 2'b00) && s_rd_req[own] && coord_ok(s_rd_coord[own]);
    wr_ok = (grant_q != 2'b00) && s_wr_req[own] && coord_ok(s_wr_coord[own]);
    err_d = err_q;
    // Any request not from the current owner, or off the map, is flagged.
    for (int i = 0; i < 2; i++) begin
      if (s_rd_req[i] && !(grant_q[i] && coord_ok(s_rd_coord[i]))) err_d = 1'b1;
      if (s_wr_req[i] && !(grant_q[i] && coord_ok(s_wr_coord[i]))) err_d = 1'b1;
    end
    rd_valid_d     = rd_ok ? grant_q : 2'b00;
    bram_rd_en     = rd_ok;
    bram_rd_addr   = rd_ok ? coord_addr(s_rd_coord[own]) : '0;
    bram_wr_en     = wr_ok;
    bram_wr_addr   = wr_ok ? coord_addr(s_wr_coord[own]) : '0;
    bram_wr_data   = wr_ok ? s_wr_data[own] : '0;
    s_grant        = grant_q;
    s_rd_valid     = rd_valid_q;
    s_rd_data      = (rd_valid_q != 2'b00) ? bram_rd_data : '0;
    protocol_error = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      rd_valid_q  <= 2'b00;
      last_fire_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rd_valid_q  <= rd_valid_d;
      last_fire_q <= last_fire_d;
      err_q       <= err_d;
    end
  end

endmodule
